// File: rtl/wbit_reg_file_pkg.sv
// Shared sizing constants for the four-entry CPU register bank.
package wbit_reg_file_pkg;

  localparam int NUM_REGS = 4;
  localparam int ADDR_W   = 2;
  localparam int DEF_W    = 4;

endpackage : wbit_reg_file_pkg

// File: rtl/wbit_reg_file_reg_cell.sv
// One W-bit storage register with synchronous active-low clear and load enable.
module wbit_reg_cell
  import wbit_reg_file_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] value_d;
  logic [W-1:0] value_q;

  always_comb begin
    value_d = value_q;
    if (en) begin
      value_d = d;
    end
  end

  // Clear wins over a pending load on the same edge.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign q = value_q;

endmodule : wbit_reg_cell

// File: rtl/wbit_reg_file.sv
// Four-entry general-purpose register bank: one synchronous write port,
// two combinational read ports with no write-to-read bypass.
module wbit_reg_file
  import wbit_reg_file_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic [W-1:0]      InA,
  input  logic              WEN,
  input  logic [ADDR_W-1:0] Add0,
  input  logic [ADDR_W-1:0] Add1,
  input  logic [ADDR_W-1:0] Add2,
  output logic [W-1:0]      Out0,
  output logic [W-1:0]      Out1
);

  logic [NUM_REGS-1:0] wr_en;
  logic [W-1:0]        regs [NUM_REGS];

  always_comb begin
    wr_en = '0;
    if (WEN) begin
      wr_en[Add2] = 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      wbit_reg_cell #(.W(W)) u_cell (
        .clk   (CLK),
        .res_n (RES),
        .en    (wr_en[gi]),
        .d     (InA),
        .q     (regs[gi])
      );
    end
  endgenerate

  // Reads see stored state only, so a same-cycle write shows up after the edge.
  assign Out0 = regs[Add0];
  assign Out1 = regs[Add1];

endmodule : wbit_reg_file

// File: tb/tb_wbit_reg_file.sv
// Randomized and directed checks of wbit_reg_file against an array-based model.
module tb_wbit_reg_file;

  logic       CLK = 1'b0;
  logic       RES = 1'b1;
  logic [3:0] InA = '0;
  logic       WEN = 1'b0;
  logic [1:0] Add0 = '0;
  logic [1:0] Add1 = '0;
  logic [1:0] Add2 = '0;
  logic [3:0] Out0;
  logic [3:0] Out1;

  logic [3:0] ref_r [4];
  int checks = 0;
  int errors = 0;
  int txn = 0;

  wbit_reg_file #(.W(4)) dut (
    .CLK  (CLK),
    .RES  (RES),
    .InA  (InA),
    .WEN  (WEN),
    .Add0 (Add0),
    .Add1 (Add1),
    .Add2 (Add2),
    .Out0 (Out0),
    .Out1 (Out1)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Apply one clock edge with the given write-side inputs and advance the model.
  task automatic clock_step(input logic res, input logic wen, input logic [3:0] ina,
                            input logic [1:0] a2);
    RES = res; WEN = wen; InA = ina; Add2 = a2;
    @(posedge CLK);
    if (!res) begin
      for (int i = 0; i < 4; i++) ref_r[i] = 4'd0;
    end else if (wen) begin
      ref_r[a2] = ina;
    end
    #1;
    txn++;
    $display("txn %0d: RES=%b WEN=%b InA=%b Add2=%0d", txn, res, wen, ina, a2);
  endtask

  task automatic read_check(input string tag, input logic [1:0] a0, input logic [1:0] a1);
    Add0 = a0; Add1 = a1;
    #1;
    check_eq({tag, "_out0"}, Out0, ref_r[a0]);
    check_eq({tag, "_out1"}, Out1, ref_r[a1]);
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 4; a++) begin
      Add0 = 2'(a); Add1 = 2'(3 - a);
      #1;
      check_eq({tag, "_out0"}, Out0, 4'd0);
      check_eq({tag, "_out1"}, Out1, 4'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) ref_r[i] = 4'hx;
    @(negedge CLK);

    // Reset beats an active write.
    clock_step(1'b0, 1'b1, 4'b1100, 2'd0);
    read_all_zero("reset");

    // Basic writes and reads.
    clock_step(1'b1, 1'b1, 4'b1100, 2'd0);
    clock_step(1'b1, 1'b1, 4'b0011, 2'd1);
    Add0 = 2'd0; Add1 = 2'd1; #1;
    check_eq("wr0", Out0, 4'b1100);
    check_eq("wr1", Out1, 4'b0011);

    clock_step(1'b1, 1'b1, 4'b0001, 2'd3);
    Add1 = 2'd3; #1;
    check_eq("wr3", Out1, 4'b0001);
    check_eq("wr3_r0", Out0, 4'b1100);

    // Write disabled.
    clock_step(1'b1, 1'b0, 4'b1111, 2'd0);
    Add0 = 2'd0; #1;
    check_eq("wen0", Out0, 4'b1100);

    // Read-during-write: old value before the edge, new after.
    Add0 = 2'd2; RES = 1'b1; WEN = 1'b1; InA = 4'b1010; Add2 = 2'd2; #1;
    check_eq("rdw_before", Out0, 4'b0000);
    clock_step(1'b1, 1'b1, 4'b1010, 2'd2);
    check_eq("rdw_after", Out0, 4'b1010);
    check_eq("rdw_model", Out0, ref_r[2]);

    // RES pulse between edges must not clear anything.
    WEN = 1'b0;
    RES = 1'b0; #1;
    read_check("no_async", 2'd0, 2'd3);
    RES = 1'b1; #1;
    read_check("res_glitch", 2'd2, 2'd1);
    @(negedge CLK);

    // Reset mid-operation with all registers non-zero.
    clock_step(1'b1, 1'b1, 4'b0110, 2'd2);
    read_check("pre_reset", 2'd1, 2'd2);
    clock_step(1'b0, 1'b1, 4'b1111, 2'd1);
    read_all_zero("mid_reset");

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic r, w;
      logic [3:0] d;
      logic [1:0] a2, a0, a1;
      r  = ($urandom_range(15) != 0);
      w  = $urandom_range(1);
      d  = 4'($urandom);
      a2 = 2'($urandom);
      a0 = 2'($urandom);
      a1 = ($urandom_range(3) == 0) ? a0 : 2'($urandom);
      Add0 = a0; Add1 = a1; RES = r; WEN = w; InA = d; Add2 = a2; #1;
      check_eq("rnd_pre_out0", Out0, ref_r[a0]);
      check_eq("rnd_pre_out1", Out1, ref_r[a1]);
      clock_step(r, w, d, a2);
      read_check("rnd_post", a0, a1);
      @(negedge CLK);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_wbit_reg_file

// File: doc/wbit_reg_file.md
Name: wbit_reg_file

Overview:
- Parameterised register file: four W-bit registers, two combinational read ports and one synchronous write port.
- Acts as the general-purpose register bank of the basic CPU datapath.
- Feeds the ALU operands (Out0, Out1) and accepts results on InA.

Parameters:
- W, 4, data width in bits of every register, of the write data and of the read data.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RES  input  1  synchronous active-low reset; RES=0 at a rising CLK edge clears all registers.
- InA  input  W  write data.
- WEN  input  1  write enable, active-high.
- Add0  input  2  read address for port 0.
- Add1  input  2  read address for port 1.
- Add2  input  2  write address.
- Out0  output  W  contents of register[Add0].
- Out1  output  W  contents of register[Add1].

Interface decision: one clock (CLK); reset is synchronous and active-low (RES).

Behaviour:
- Storage: registers R0..R3, each W bits.
- Reset (rising CLK edge with RES=0):
  - R0..R3 all become 0.
  - Reset has priority over WEN; no write occurs in a reset cycle.
  - RES changing between edges has no effect; there is no asynchronous clear.
- Write (rising CLK edge with RES=1 and WEN=1):
  - R[Add2] <= InA.
  - The other three registers hold their value.
- Hold: with RES=1 and WEN=0, all registers hold.
- Reads:
  - Out0 = R[Add0] and Out1 = R[Add1], purely combinational with zero-cycle latency from an address change.
  - Both ports may address the same register simultaneously and then return identical data.
- Read-during-write:
  - No bypass. A read of the register being written returns the old value until the rising edge, and the new value immediately after it.
- Power-up: register contents are undefined until the first reset edge. Outputs reflect whatever is stored.
- Unknown address (X) on a read port: the output is X. There is no other error handling.
- Width rules: no arithmetic. InA is stored bit-for-bit with no extension or truncation.
- No handshake. A write takes effect on the single edge on which WEN is sampled high.

Decomposition:
- Shared package: constant NUM_REGS=4 and ADDR_W=2, plus the default data width constant.
- One natural sub-module, wbit_reg_cell: a W-bit register with synchronous active-low clear and an enable. It is instantiated four times.
- Top-level logic:
  - The write-address decode produces a one-hot enable, gated by WEN.
  - Two 4:1 W-bit read multiplexers drive Out0 and Out1.

Test Plan:
1. Reset: hold RES=0 for one rising edge with WEN=1, InA=4'b1100, Add2=0 -> R0 stays 0. Out0 and Out1 read 0 for addresses 0..3.
2. Basic write/read: RES=1, WEN=1.
   - Write 4'b1100 to address 0, then 4'b0011 to address 1.
   - Set Add0=0, Add1=1 -> Out0=4'b1100, Out1=4'b0011.
3. Write to address 3:
   - Add2=3, InA=4'b0001, rising edge.
   - Set Add1=3 -> Out1=4'b0001.
   - Out0 still 4'b1100.
4. Write-disable: WEN=0, Add2=0, InA=4'b1111, rising edge -> Out0 (Add0=0) remains 4'b1100.
5. Read-during-write:
   - Add0=2 and Add2=2 with R2=0, InA=4'b1010.
   - Before the edge Out0=0; after the edge Out0=4'b1010.
6. Reset mid-operation:
   - With R0..R3 non-zero, drive RES=0 and WEN=1 for one edge -> all outputs read 0 for all addresses.
   - Deasserting RES between edges alone changes nothing.
